// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and helpers for the memory port arbiter
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_AW      = 16;
  localparam int DEF_DW      = 16;

  typedef struct packed {
    logic rd;
    logic wr;
    logic dump;
  } mem_cmd_t;

  // On a tie the requester that was not served last wins.
  function automatic logic pick_owner(logic req_i, logic req_d, logic last_owner);
    if (req_i && req_d) begin
      return (last_owner == OWN_I) ? OWN_D : OWN_I;
    end
    return req_d ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-side signals of the arbiter
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic          i_rd;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_data;
  logic          i_done;
  logic          i_stall;
  logic          i_err;

  logic          d_rd;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_halt;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          d_stall;
  logic          d_err;

  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_rd;
  logic          m_wr;
  logic          m_createdump;
  logic [DW-1:0] m_rdata;
  logic          m_done;
  logic          m_err;

  modport master (
    input  i_rd, i_addr, d_rd, d_wr, d_addr, d_wdata, d_halt,
    input  m_rdata, m_done, m_err,
    output i_data, i_done, i_stall, i_err,
    output d_rdata, d_done, d_stall, d_err,
    output m_addr, m_wdata, m_rd, m_wr, m_createdump
  );

  modport slave (
    output i_rd, i_addr, d_rd, d_wr, d_addr, d_wdata, d_halt,
    output m_rdata, m_done, m_err,
    input  i_data, i_done, i_stall, i_err,
    input  d_rdata, d_done, d_stall, d_err,
    input  m_addr, m_wdata, m_rd, m_wr, m_createdump
  );

endinterface

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - counts BUSY cycles and flags a transaction that never completes
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // The first BUSY cycle sees count 0, so expire fires in the TIMEOUT-th BUSY cycle.
  assign expire = (TIMEOUT != 0) && en && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expire) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one mem_system between the fetch and data ports
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW
) (
  input logic          clk,
  input logic          rst,
  mem_port_arbiter_if.master bus
);

  logic [1:0]    state;
  logic          owner;
  logic          last_owner;
  mem_cmd_t      cmd_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;

  logic req_i;
  logic req_d;
  logic grant;
  logic grant_owner;
  logic busy;
  logic resp;
  logic expire;

  assign busy = (state == ST_BUSY);
  assign resp = (state == ST_RESP);

  // A halt alone still needs a slot so the memory can be dumped.
  always_comb begin
    req_i       = bus.i_rd;
    req_d       = bus.d_rd | bus.d_wr | bus.d_halt;
    grant       = 1'b0;
    grant_owner = OWN_I;
    case (state)
      ST_IDLE: begin
        if (req_i || req_d) begin
          grant       = 1'b1;
          grant_owner = pick_owner(req_i, req_d, last_owner);
        end
      end
      ST_RESP: begin
        // The owner's level request is stale here; only the other side may be granted.
        if (owner == OWN_I && req_d) begin
          grant       = 1'b1;
          grant_owner = OWN_D;
        end else if (owner == OWN_D && req_i) begin
          grant       = 1'b1;
          grant_owner = OWN_I;
        end
      end
      default: ;
    endcase
  end

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (grant),
    .en     (busy),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_I;
      cmd_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_BUSY: begin
          if (bus.m_done) begin
            rdata_q <= bus.m_rdata;
            err_q   <= bus.m_err;
            state   <= ST_RESP;
          end else if (expire) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end
        end
        default: begin
          if (grant) begin
            state      <= ST_BUSY;
            owner      <= grant_owner;
            last_owner <= grant_owner;
            if (grant_owner == OWN_D) begin
              addr_q     <= bus.d_addr;
              wdata_q    <= bus.d_wdata;
              cmd_q.rd   <= bus.d_rd & ~bus.d_wr;
              cmd_q.wr   <= bus.d_wr & ~bus.d_halt;
              cmd_q.dump <= bus.d_halt;
            end else begin
              addr_q     <= bus.i_addr;
              wdata_q    <= '0;
              cmd_q.rd   <= 1'b1;
              cmd_q.wr   <= 1'b0;
              cmd_q.dump <= 1'b0;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Strobes are also gated by reset so an abort is seen by the memory in the same cycle.
  assign bus.m_addr       = addr_q;
  assign bus.m_wdata      = wdata_q;
  assign bus.m_rd         = busy & cmd_q.rd & rst;
  assign bus.m_wr         = busy & cmd_q.wr & rst;
  assign bus.m_createdump = busy & cmd_q.dump & rst;

  assign bus.i_done  = resp & (owner == OWN_I);
  assign bus.d_done  = resp & (owner == OWN_D);
  assign bus.i_data  = bus.i_done ? rdata_q : '0;
  assign bus.d_rdata = bus.d_done ? rdata_q : '0;
  assign bus.i_err   = bus.i_done & err_q;
  assign bus.d_err   = bus.d_done & err_q;

  assign bus.i_stall = bus.i_rd & ~bus.i_done;
  assign bus.d_stall = (bus.d_rd | bus.d_wr) & ~bus.d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_port_arbiter #(
    .TIMEOUT (8),
    .AW      (16),
    .DW      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    bus.i_rd = 0; bus.i_addr = '0; bus.d_rd = 0; bus.d_wr = 0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_halt = 0; bus.m_rdata = '0; bus.m_done = 0; bus.m_err = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 0;
    tick(); tick();
    settle();
    vectors++; if ({bus.m_rd, bus.m_wr, bus.m_createdump} !== 3'b000) begin miscompares++; $display("FAIL reset_mstrobes got=%b exp=000", {bus.m_rd, bus.m_wr, bus.m_createdump}); end
    vectors++; if ({bus.m_addr, bus.m_wdata} !== 32'h0) begin miscompares++; $display("FAIL reset_mbus got=%h exp=0", {bus.m_addr, bus.m_wdata}); end
    vectors++; if ({bus.i_done, bus.d_done, bus.i_err, bus.d_err} !== 4'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0000", {bus.i_done, bus.d_done, bus.i_err, bus.d_err}); end
    vectors++; if ({bus.i_data, bus.d_rdata} !== 32'h0) begin miscompares++; $display("FAIL reset_data got=%h exp=0", {bus.i_data, bus.d_rdata}); end
    rst = 1;
    tick();
  endtask

  task automatic test_single_fetch;
    bus.i_rd = 1; bus.i_addr = 16'h0040;
    settle();
    vectors++; if (bus.i_stall !== 1'b1) begin miscompares++; $display("FAIL t1_stall_req got=%b exp=1", bus.i_stall); end
    vectors++; if (bus.d_stall !== 1'b0) begin miscompares++; $display("FAIL t1_dstall got=%b exp=0", bus.d_stall); end
    vectors++; if (bus.m_rd !== 1'b0) begin miscompares++; $display("FAIL t1_mrd_idle got=%b exp=0", bus.m_rd); end
    tick();
    vectors++; if (bus.m_rd !== 1'b1) begin miscompares++; $display("FAIL t1_mrd_grant got=%b exp=1", bus.m_rd); end
    vectors++; if (bus.m_addr !== 16'h0040) begin miscompares++; $display("FAIL t1_maddr got=%h exp=0040", bus.m_addr); end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if ({bus.m_rd, bus.i_done, bus.i_stall} !== 3'b101) begin miscompares++; $display("FAIL t1_wait%0d got=%b exp=101", k, {bus.m_rd, bus.i_done, bus.i_stall}); end
    end
    tick();
    bus.m_done = 1; bus.m_rdata = 16'hBEEF;
    settle();
    vectors++; if ({bus.i_done, bus.i_stall} !== 2'b01) begin miscompares++; $display("FAIL t1_mdone_cycle got=%b exp=01", {bus.i_done, bus.i_stall}); end
    tick();
    bus.m_done = 0; bus.m_rdata = '0;
    settle();
    vectors++; if (bus.i_done !== 1'b1) begin miscompares++; $display("FAIL t1_idone got=%b exp=1", bus.i_done); end
    vectors++; if (bus.i_data !== 16'hBEEF) begin miscompares++; $display("FAIL t1_idata got=%h exp=beef", bus.i_data); end
    vectors++; if ({bus.i_stall, bus.i_err, bus.m_rd, bus.d_done} !== 4'b0000) begin miscompares++; $display("FAIL t1_resp_misc got=%b exp=0000", {bus.i_stall, bus.i_err, bus.m_rd, bus.d_done}); end
    bus.i_rd = 0;
    tick();
    vectors++; if (bus.i_done !== 1'b0) begin miscompares++; $display("FAIL t1_idone_pulse got=%b exp=0", bus.i_done); end
  endtask

  task automatic test_tie_alternation;
    rst = 0; tick(); rst = 1;
    bus.i_rd = 1; bus.i_addr = 16'h0200; bus.d_rd = 1; bus.d_addr = 16'h0100;
    tick();
    vectors++; if ({bus.m_rd, bus.m_addr} !== {1'b1, 16'h0100}) begin miscompares++; $display("FAIL t2_first_data got=%h exp=10100", {bus.m_rd, bus.m_addr}); end
    bus.m_done = 1; bus.m_rdata = 16'hD00D;
    tick();
    bus.m_done = 0;
    settle();
    vectors++; if ({bus.d_done, bus.i_done, bus.d_rdata} !== {2'b10, 16'hD00D}) begin miscompares++; $display("FAIL t2_ddone got=%h exp=2d00d", {bus.d_done, bus.i_done, bus.d_rdata}); end
    vectors++; if ({bus.d_stall, bus.i_stall} !== 2'b01) begin miscompares++; $display("FAIL t2_stalls got=%b exp=01", {bus.d_stall, bus.i_stall}); end
    bus.d_rd = 0;
    tick();
    vectors++; if ({bus.m_rd, bus.m_addr} !== {1'b1, 16'h0200}) begin miscompares++; $display("FAIL t2_no_bubble got=%h exp=10200", {bus.m_rd, bus.m_addr}); end
    bus.m_done = 1; bus.m_rdata = 16'h1111;
    tick();
    bus.m_done = 0;
    settle();
    vectors++; if ({bus.i_done, bus.i_data} !== {1'b1, 16'h1111}) begin miscompares++; $display("FAIL t2_idone got=%h exp=11111", {bus.i_done, bus.i_data}); end
    bus.i_rd = 0;
    tick();
    bus.i_rd = 1; bus.d_rd = 1;
    tick();
    vectors++; if (bus.m_addr !== 16'h0100) begin miscompares++; $display("FAIL t2_tie2_data got=%h exp=0100", bus.m_addr); end
    bus.m_done = 1; bus.m_rdata = 16'h2222;
    tick();
    bus.m_done = 0;
    settle();
    vectors++; if ({bus.d_done, bus.d_rdata} !== {1'b1, 16'h2222}) begin miscompares++; $display("FAIL t2_tie2_done got=%h exp=12222", {bus.d_done, bus.d_rdata}); end
    bus.i_rd = 0; bus.d_rd = 0;
    tick();
    bus.i_rd = 1; bus.d_rd = 1;
    tick();
    vectors++; if (bus.m_addr !== 16'h0200) begin miscompares++; $display("FAIL t2_tie3_fetch got=%h exp=0200", bus.m_addr); end
    bus.m_done = 1; bus.m_rdata = 16'h3333;
    tick();
    bus.m_done = 0;
    settle();
    vectors++; if ({bus.i_done, bus.i_data} !== {1'b1, 16'h3333}) begin miscompares++; $display("FAIL t2_tie3_done got=%h exp=13333", {bus.i_done, bus.i_data}); end
    bus.i_rd = 0; bus.d_rd = 0;
    tick();
  endtask

  task automatic test_halted_write;
    bus.d_wr = 1; bus.d_halt = 1; bus.d_addr = 16'h0010; bus.d_wdata = 16'h1234;
    tick();
    vectors++; if ({bus.m_wr, bus.m_rd, bus.m_createdump} !== 3'b001) begin miscompares++; $display("FAIL t3_strobes got=%b exp=001", {bus.m_wr, bus.m_rd, bus.m_createdump}); end
    vectors++; if ({bus.m_addr, bus.m_wdata} !== {16'h0010, 16'h1234}) begin miscompares++; $display("FAIL t3_mbus got=%h exp=00101234", {bus.m_addr, bus.m_wdata}); end
    tick();
    vectors++; if ({bus.m_createdump, bus.m_wr, bus.d_done} !== 3'b100) begin miscompares++; $display("FAIL t3_hold got=%b exp=100", {bus.m_createdump, bus.m_wr, bus.d_done}); end
    bus.m_done = 1;
    tick();
    bus.m_done = 0;
    settle();
    vectors++; if ({bus.d_done, bus.m_createdump} !== 2'b10) begin miscompares++; $display("FAIL t3_done got=%b exp=10", {bus.d_done, bus.m_createdump}); end
    bus.d_wr = 0; bus.d_halt = 0;
    tick();
  endtask

  task automatic test_error;
    bus.d_rd = 1; bus.d_addr = 16'h0022;
    tick();
    bus.m_done = 1; bus.m_err = 1; bus.m_rdata = 16'h5555;
    tick();
    bus.m_done = 0; bus.m_err = 0;
    settle();
    vectors++; if ({bus.d_done, bus.d_err, bus.d_rdata} !== {2'b11, 16'h5555}) begin miscompares++; $display("FAIL t5_err got=%h exp=35555", {bus.d_done, bus.d_err, bus.d_rdata}); end
    bus.d_rd = 0;
    tick();
    vectors++; if ({bus.d_done, bus.d_err} !== 2'b00) begin miscompares++; $display("FAIL t5_err_pulse got=%b exp=00", {bus.d_done, bus.d_err}); end
    bus.m_done = 1;
    tick();
    bus.m_done = 0;
    settle();
    vectors++; if ({bus.d_done, bus.i_done, bus.m_rd} !== 3'b000) begin miscompares++; $display("FAIL t5_stray_mdone got=%b exp=000", {bus.d_done, bus.i_done, bus.m_rd}); end
  endtask

  task automatic test_watchdog;
    bus.m_rdata = 16'hFFFF;
    bus.i_rd = 1; bus.i_addr = 16'h0300;
    tick();
    for (int k = 1; k <= 8; k++) begin
      vectors++; if ({bus.m_rd, bus.i_done} !== 2'b10) begin miscompares++; $display("FAIL t4_busy%0d got=%b exp=10", k, {bus.m_rd, bus.i_done}); end
      tick();
    end
    vectors++; if ({bus.m_rd, bus.i_done, bus.i_err} !== 3'b011) begin miscompares++; $display("FAIL t4_abort got=%b exp=011", {bus.m_rd, bus.i_done, bus.i_err}); end
    vectors++; if (bus.i_data !== 16'h0000) begin miscompares++; $display("FAIL t4_abort_data got=%h exp=0000", bus.i_data); end
    bus.i_rd = 0;
    tick();
    bus.i_rd = 1; bus.i_addr = 16'h0044;
    tick();
    vectors++; if ({bus.m_rd, bus.m_addr} !== {1'b1, 16'h0044}) begin miscompares++; $display("FAIL t4_next_grant got=%h exp=10044", {bus.m_rd, bus.m_addr}); end
    bus.m_done = 1; bus.m_rdata = 16'hABCD;
    tick();
    bus.m_done = 0;
    settle();
    vectors++; if ({bus.i_done, bus.i_err, bus.i_data} !== {2'b10, 16'hABCD}) begin miscompares++; $display("FAIL t4_next_done got=%h exp=2abcd", {bus.i_done, bus.i_err, bus.i_data}); end
    bus.i_rd = 0;
    tick();
  endtask

  task automatic test_reset_mid_busy;
    bus.d_rd = 1; bus.d_addr = 16'h0050;
    tick();
    tick();
    vectors++; if (bus.m_rd !== 1'b1) begin miscompares++; $display("FAIL t6_busy got=%b exp=1", bus.m_rd); end
    rst = 0; bus.d_rd = 0;
    settle();
    vectors++; if (bus.m_rd !== 1'b0) begin miscompares++; $display("FAIL t6_mrd_drop got=%b exp=0", bus.m_rd); end
    tick();
    vectors++; if ({bus.m_rd, bus.m_wr, bus.m_createdump, bus.i_done, bus.d_done, bus.i_stall, bus.d_stall} !== 7'b0) begin miscompares++; $display("FAIL t6_ctrl_zero got=%b exp=0000000", {bus.m_rd, bus.m_wr, bus.m_createdump, bus.i_done, bus.d_done, bus.i_stall, bus.d_stall}); end
    vectors++; if ({bus.m_addr, bus.m_wdata, bus.d_rdata, bus.i_data} !== 64'h0) begin miscompares++; $display("FAIL t6_data_zero got=%h exp=0", {bus.m_addr, bus.m_wdata, bus.d_rdata, bus.i_data}); end
    rst = 1;
    tick();
    vectors++; if ({bus.d_done, bus.i_done} !== 2'b00) begin miscompares++; $display("FAIL t6_no_done got=%b exp=00", {bus.d_done, bus.i_done}); end
    bus.i_rd = 1; bus.i_addr = 16'h0200; bus.d_rd = 1; bus.d_addr = 16'h0100;
    tick();
    vectors++; if ({bus.m_rd, bus.m_addr} !== {1'b1, 16'h0100}) begin miscompares++; $display("FAIL t6_fresh_data got=%h exp=10100", {bus.m_rd, bus.m_addr}); end
    bus.m_done = 1; bus.m_rdata = 16'h6666;
    tick();
    bus.m_done = 0;
    settle();
    vectors++; if ({bus.d_done, bus.d_rdata} !== {1'b1, 16'h6666}) begin miscompares++; $display("FAIL t6_fresh_done got=%h exp=16666", {bus.d_done, bus.d_rdata}); end
    bus.i_rd = 0; bus.d_rd = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_tie_alternation();
    test_halted_write();
    test_error();
    test_watchdog();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
